// File: rtl/div_issue_queue.sv
// Operand FIFO and issue stage in front of a combinational array divider.
// Holds dividend/divisor pairs, drives one pair at a time, and returns results over valid/ready.
module div_issue_queue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    input  logic [WIDTH-1:0]         div_q,
    input  logic [WIDTH-1:0]         div_r,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_q,
    output logic [WIDTH-1:0]         out_r,
    output logic                     out_dbz,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                 state, state_next;
    logic [2*WIDTH-1:0]     mem [DEPTH];
    logic [2*WIDTH-1:0]     head;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic                   push, load, capture, release_out;

    // in_ready comes only from the registered occupancy, never from in_valid
    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    if (count != '0) begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_a, in_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a <= '0;
            div_b <= '0;
        end else if (load) begin
            div_a <= head[2*WIDTH-1:WIDTH];
            div_b <= head[WIDTH-1:0];
        end
    end

    // Divide-by-zero is resolved here so the divider's output for B=0 never matters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_dbz   <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            if (div_b == '0) begin
                out_q   <= {WIDTH{1'b1}};
                out_r   <= div_a;
                out_dbz <= 1'b1;
            end else begin
                out_q   <= div_q;
                out_r   <= div_r;
                out_dbz <= 1'b0;
            end
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed self-checking bench for div_issue_queue with a behavioural divider model.
module tb_div_issue_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0, in_b = '0;
    logic [3:0] div_a, div_b, div_q, div_r;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_q, out_r;
    logic       out_dbz;
    logic [2:0] count;
    logic       force_zero = 1'b0;

    int errors = 0;
    int checks = 0;

    div_issue_queue #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .count(count)
    );

    always #5 clk = ~clk;

    // Divider model; force_zero proves the dbz path ignores it
    always_comb begin
        div_q = '0;
        div_r = '0;
        if (!force_zero && div_b != 0) begin
            div_q = div_a / div_b;
            div_r = div_a % div_b;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({out_valid, out_q, out_r, out_dbz, div_a, div_b} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0", {out_valid, out_q, out_r, out_dbz, div_a, div_b});
        end
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_count: got count=%0d in_ready=%0b expected count=0 in_ready=1", count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_a = 4'd15; in_b = 4'd3;
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_push: got count=%0d valid=%0b expected count=1 valid=0", count, out_valid);
        end
        step();
        checks++;
        if (div_a !== 4'd15 || div_b !== 4'd3 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_load: got a=%0d b=%0d count=%0d expected a=15 b=3 count=0", div_a, div_b, count);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_q !== 4'd5 || out_r !== 4'd0 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got v=%0b q=%0d r=%0d dbz=%0b expected v=1 q=5 r=0 dbz=0",
                     out_valid, out_q, out_r, out_dbz);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_handshake: got valid=%0b expected 0", out_valid);
        end
    endtask

    task automatic test_dbz();
        force_zero = 1'b1;
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd0;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_q !== 4'd15 || out_r !== 4'd9 || out_dbz !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: got v=%0b q=%0d r=%0d dbz=%0b expected v=1 q=15 r=9 dbz=1",
                     out_valid, out_q, out_r, out_dbz);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        force_zero = 1'b0;
    endtask

    task automatic test_stream();
        logic [3:0] sa [4] = '{4'd5, 4'd10, 4'd7, 4'd9};
        logic [3:0] sb [4] = '{4'd2, 4'd4, 4'd3, 4'd5};
        logic [3:0] eq [4] = '{4'd2, 4'd2, 4'd2, 4'd1};
        logic [3:0] er [4] = '{4'd1, 4'd2, 4'd1, 4'd4};
        int got = 0;
        int last = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_ready: got %0b expected 1 at cycle %0d", in_ready, c);
                end
                in_valid = 1'b1; in_a = sa[c]; in_b = sb[c];
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid === 1'b1 && got < 4) begin
                checks++;
                if (out_q !== eq[got] || out_r !== er[got] || out_dbz !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_result%0d: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=0",
                             got, out_q, out_r, out_dbz, eq[got], er[got]);
                end
                if (got > 0) begin
                    checks++;
                    if (c - last != 2) begin
                        errors++;
                        $display("FAIL stream_spacing%0d: got %0d cycles expected 2", got, c - last);
                    end
                end
                last = c;
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL stream_count: got %0d results expected 4", got);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] pa [5] = '{4'd8, 4'd9, 4'd13, 4'd11, 4'd14};
        logic [3:0] pb [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [3:0] eq [5] = '{4'd4, 4'd3, 4'd3, 4'd2, 4'd2};
        logic [3:0] er [5] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
        int acc = 0;
        int got = 1;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_a = pa[acc < 5 ? acc : 4];
            in_b = pb[acc < 5 ? acc : 4];
            if (in_ready === 1'b1) acc++;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (acc != 5 || in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL bp_full: got accepts=%0d in_ready=%0b count=%0d expected 5 0 4", acc, in_ready, count);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_q !== eq[0] || out_r !== er[0] || count !== 3'd4) begin
            errors++;
            $display("FAIL bp_frozen: got v=%0b q=%0d r=%0d count=%0d expected v=1 q=4 r=0 count=4",
                     out_valid, out_q, out_r, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pulse: got v=%0b count=%0d in_ready=%0b expected v=0 count=3 in_ready=1",
                     out_valid, count, in_ready);
        end
        step();
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_q !== eq[1] || out_r !== er[1] || count !== 3'd3) begin
            errors++;
            $display("FAIL bp_one_drained: got v=%0b q=%0d r=%0d count=%0d expected v=1 q=3 r=0 count=3",
                     out_valid, out_q, out_r, count);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_q !== eq[got] || out_r !== er[got]) begin
                    errors++;
                    $display("FAIL bp_drain%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                             got, out_q, out_r, eq[got], er[got]);
                end
                got++;
            end
            step();
        end
        checks++;
        if (got != 5 || count !== 3'd0) begin
            errors++;
            $display("FAIL bp_drain_done: got results=%0d count=%0d expected 5 0", got, count);
        end
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        logic [3:0] qa [$];
        logic [3:0] qb [$];
        int pushed = 0;
        int got = 0;
        logic [3:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = 4'((i * 7 + 3) % 16);
            b = 4'((i % 7) + 1);
            qa.push_back(a);
            qb.push_back(b);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && got < 12; c++) begin
            if (in_ready === 1'b1 && pushed < 12) begin
                in_valid = 1'b1; in_a = qa[pushed]; in_b = qb[pushed];
                pushed++;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid === 1'b1) begin
                checks++;
                if (out_q !== qa[got] / qb[got] || out_r !== qa[got] % qb[got]) begin
                    errors++;
                    $display("FAIL wrap_result%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                             got, out_q, out_r, qa[got] / qb[got], qa[got] % qb[got]);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (got != 12 || count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_done: got results=%0d count=%0d expected 12 0", got, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 4'(12 - i); in_b = 4'd2;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_setup: got count=%0d v=%0b expected count=3 v=1", count, out_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_q, out_r, out_dbz, div_a, div_b} !== 15'd0 || count !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_async: got outs=%0h count=%0d in_ready=%0b expected 0 0 1",
                     {out_valid, out_q, out_r, out_dbz, div_a, div_b}, count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd3;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || div_a !== 4'd7 || div_b !== 4'd3) begin
            errors++;
            $display("FAIL rmid_no_stale: got v=%0b a=%0d b=%0d expected v=0 a=7 b=3", out_valid, div_a, div_b);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_q !== 4'd2 || out_r !== 4'd1) begin
            errors++;
            $display("FAIL rmid_result: got v=%0b q=%0d r=%0d expected v=1 q=2 r=1", out_valid, out_q, out_r);
        end
        out_ready = 1'b1;
        step();
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL rmid_empty: got v=%0b count=%0d expected v=0 count=0", out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dbz();
        test_stream();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_issue_queue.md
# div_issue_queue

Operand staging and issue stage that sits directly upstream of the combinational 4-bit array divider (`divider_4bit`). It buffers dividend/divisor pairs from a producer in a small FIFO and drives one pair at a time into the divider from registers. It captures the divider's quotient/remainder one cycle later and presents the result to a consumer over a valid/ready handshake. Divide-by-zero is detected here and never depends on the divider's output.

## Interface
Parameters:
- `WIDTH`, default 4: operand/result width; must match the divider.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: producer has a pair on `in_a`/`in_b`.
- `in_ready`  out  1: FIFO can accept; high when `count < DEPTH`.
- `in_a`  in  WIDTH: dividend.
- `in_b`  in  WIDTH: divisor.
- `div_a`  out  WIDTH: registered dividend to the divider's `A`.
- `div_b`  out  WIDTH: registered divisor to the divider's `B`.
- `div_q`  in  WIDTH: quotient from the divider's `Q`.
- `div_r`  in  WIDTH: remainder from the divider's `R`.
- `out_valid`  out  1: result registers hold a valid result.
- `out_ready`  in  1: consumer accepts the result.
- `out_q`  out  WIDTH: quotient.
- `out_r`  out  WIDTH: remainder.
- `out_dbz`  out  1: divide-by-zero flag for this result.
- `count`  out  log2(DEPTH)+1: FIFO occupancy. The entry in flight is not counted.

## Operation
- Push: on a rising edge where `in_valid && in_ready`, write `{in_a,in_b}` at the write pointer and increment the write pointer.
- Pointers wrap modulo DEPTH.
- `count` is the true occupancy, 0..DEPTH.
- Pop: occurs only as part of an FSM load, and only when `count != 0`.
- When push and pop happen in the same cycle, `count` is unchanged.
- There is no bypass: an entry pushed at edge N is visible to the FSM from N+1.
- FSM states are `IDLE`, `ISSUE` and `HOLD`:
  - `IDLE`: if `count != 0`, load the head into `div_a`/`div_b`, pop, and go to `ISSUE`. Otherwise stay.
  - `ISSUE`: the divider has had one full cycle to settle. Capture `out_q <= div_q`, `out_r <= div_r`, `out_dbz <= 0`, set `out_valid`, and go to `HOLD`.
  - `ISSUE`, divide-by-zero case: if `div_b == 0`, capture `out_q <= {WIDTH{1'b1}}`, `out_r <= div_a`, `out_dbz <= 1` instead, ignoring `div_q`/`div_r`.
  - `HOLD`: `out_*` stay stable while `out_ready` is low.
  - `HOLD` on `out_ready`: clear `out_valid`. If `count != 0`, load and pop the next head and go to `ISSUE`; otherwise go to `IDLE`.
- `div_a`/`div_b` keep their last value when not loading. They may change while `out_valid` is high, because the result is already captured.
- Reset (asynchronous, `rst_n` low):
  - FSM goes to `IDLE`; pointers and `count` go to 0.
  - `out_valid`, `out_q`, `out_r`, `out_dbz`, `div_a` and `div_b` go to 0.
  - `in_ready` is 1 immediately after reset (count is 0).
  - Buffered and in-flight entries are discarded.

## Timing
- Latency with the FIFO empty and the FSM idle: pair accepted at edge N, loaded to `div_*` at N+1, `out_valid` high after edge N+2.
- Throughput: one result per 2 cycles when the consumer holds `out_ready` high.
- The handshake completes on the edge where `out_valid && out_ready`. `out_valid` drops after that edge unless a new capture occurs at a later `ISSUE` edge. It never stays high across a `HOLD`→`ISSUE` transition.
- `in_ready` and `out_valid` are driven only from registered state and do not depend combinationally on `in_valid`/`out_ready`.
- Capacity with the consumer stalled: DEPTH entries in the FIFO plus one result held. With DEPTH=4, `in_ready` falls after the 5th accepted pair.

## Test plan
- Single op, 15/3: push with the FSM idle → `div_a`=15, `div_b`=3 after N+1; `out_q`=5, `out_r`=0, `out_dbz`=0, `out_valid`=1 after N+2.
- Divide-by-zero, 9/0 → `out_q`=15, `out_r`=9, `out_dbz`=1. Check that the divider's outputs are ignored by forcing the `div_q`/`div_r` model to 0.
- Stream of 5/2, 10/4, 7/3, 9/5 with `out_ready`=1, one push per cycle → results (2,1), (2,2), (2,1), (1,4) in order, spaced 2 cycles apart; no loss while `in_ready`=1.
- Backpressure: `out_ready`=0 and pushes every cycle.
  - `in_ready` drops after the 5th accept.
  - `out_*` stay frozen and `count`=4.
  - Pulsing `out_ready` for 1 cycle drains exactly one result.
  - `in_ready` returns high one cycle after the FSM pops.
- Wrap-around: push and drain 3×DEPTH operand pairs → all results are correct and in order, and `count` returns to 0.
- Reset mid-operation: assert `rst_n`=0 asynchronously (between edges) while in `HOLD` with `count`=3.
  - All outputs go to 0 at once and `count`=0; after release, `in_ready`=1.
  - The next push of 7/3 gives (2,1) with 2-cycle latency and no stale results.
